// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter with a one-word holding buffer.
// Produces gapless back-to-back frames and marks bit/frame positions.
module serial_frame_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             frame_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_full_q, hold_full_d;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] sreg_shifted;

    // Ready depends only on flops and reset, so a producer may wait on it.
    assign load_ready   = !hold_full_q && !reset;
    assign accept       = load_valid && load_ready;
    assign last_bit     = (cnt_q == LAST_CNT);
    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    sreg_d = sreg_shifted;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (accept) begin
                        hold_d      = data_in;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // Held word goes first; ready is low so no accept can race it.
                    sreg_d      = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (accept) begin
                    sreg_d = data_in;
                    cnt_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from flops
    always_comb begin
        serial_out = IDLE_BIT;
        bit_valid  = 1'b0;
        frame_done = 1'b0;
        if (state_q == SHIFT) begin
            serial_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
            bit_valid  = 1'b1;
            frame_done = last_bit;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: an MSB-first and an LSB-first instance, with
// expected bits queued on accept and popped whenever bit_valid is seen.
module tb_serial_frame_tx;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic       clock;
    logic       reset;
    logic [7:0] din [2];
    logic       vld [2];
    logic       rdy [2];
    logic       so  [2];
    logic       bv  [2];
    logic       fd  [2];
    logic       prev_bv [2];

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    serial_frame_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clock      (clock),
        .reset      (reset),
        .data_in    (din[0]),
        .load_valid (vld[0]),
        .load_ready (rdy[0]),
        .serial_out (so[0]),
        .bit_valid  (bv[0]),
        .frame_done (fd[0])
    );

    serial_frame_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clock      (clock),
        .reset      (reset),
        .data_in    (din[1]),
        .load_valid (vld[1]),
        .load_ready (rdy[1]),
        .serial_out (so[1]),
        .bit_valid  (bv[1]),
        .frame_done (fd[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic got, input logic want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s got=%b want=%b", tag, got, want);
        end
    endtask

    // Compare one lane's output against the head of its expectation queue.
    task automatic lane(input int k);
        exp_t e;
        bit   have;
        have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (bv[k] === 1'b1) begin
            checks++;
            assert (have)
            else begin
                errors++;
                $error("FAIL lane%0d_extra_bit got bit_valid=1 want 0 (nothing pending)", k);
            end
            if (have) begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("lane%0d_serial_out", k), so[k], e.b);
                chk($sformatf("lane%0d_frame_done", k), fd[k], e.last);
            end
        end else begin
            chk($sformatf("lane%0d_idle_out", k), so[k], 1'b0);
            chk($sformatf("lane%0d_idle_done", k), fd[k], 1'b0);
            if (have && prev_bv[k] === 1'b1) begin
                checks++;
                assert (1'b0)
                else begin
                    errors++;
                    $error("FAIL lane%0d_gap got bit_valid=0 want 1 (frame pending)", k);
                end
            end
        end
        prev_bv[k] = bv[k];
    endtask

    always @(negedge clock) begin
        lane(0);
        lane(1);
    end

    // Offer a word, wait (bounded) for ready, queue its bits, pass the accept edge.
    task automatic send(input int k, input logic [7:0] w, input bit keep);
        int   n;
        exp_t e;
        n = 0;
        din[k] = w;
        vld[k] = 1'b1;
        while (rdy[k] !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk($sformatf("lane%0d_send_ready", k), rdy[k], 1'b1);
        #1;
        for (int i = 0; i < 8; i++) begin
            e.b    = (k == 0) ? w[7 - i] : w[i];
            e.last = (i == 7);
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clock);
        if (!keep) vld[k] = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            din[k]     = '0;
            vld[k]     = 1'b0;
            prev_bv[k] = 1'b0;
        end
        repeat (2) @(negedge clock);
        chk("reset_ready", rdy[0], 1'b0);
        chk("reset_bit_valid", bv[0], 1'b0);
        chk("reset_serial_out", so[0], 1'b0);
        chk("reset_frame_done", fd[0], 1'b0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_ready", rdy[0], 1'b1);
        chk("post_reset_ready_lsb", rdy[1], 1'b1);

        // Basic MSB-first frame, one-cycle latency, frame_done on 8th bit
        send(0, 8'h96, 1'b0);
        chk("basic_first_bit_valid", bv[0], 1'b1);
        repeat (7) @(negedge clock);
        chk("basic_frame_done", fd[0], 1'b1);
        @(negedge clock);
        chk("basic_after_valid", bv[0], 1'b0);
        repeat (3) @(negedge clock);

        // LSB-first frame
        send(1, 8'h09, 1'b0);
        repeat (12) @(negedge clock);

        // Back-to-back through the holding register
        send(0, 8'h90, 1'b1);
        send(0, 8'h09, 1'b0);
        chk("b2b_ready_drop", rdy[0], 1'b0);
        repeat (6) @(negedge clock);
        chk("b2b_first_last", fd[0], 1'b1);
        chk("b2b_ready_still_low", rdy[0], 1'b0);
        @(negedge clock);
        chk("b2b_ready_back", rdy[0], 1'b1);
        repeat (12) @(negedge clock);

        // Bypass accept on the last-bit cycle
        send(0, 8'h3C, 1'b0);
        n = 0;
        while (fd[0] !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("bypass_found_last", fd[0], 1'b1);
        send(0, 8'hA5, 1'b0);
        chk("bypass_continuous", bv[0], 1'b1);
        repeat (12) @(negedge clock);

        // Stall: third word waits for the holding register to drain
        send(0, 8'h11, 1'b1);
        send(0, 8'h22, 1'b1);
        chk("stall_ready_low", rdy[0], 1'b0);
        send(0, 8'h33, 1'b0);
        repeat (30) @(negedge clock);
        chk("drain_msb_empty", 1'(q0.size() == 0), 1'b1);
        chk("drain_lsb_empty", 1'(q1.size() == 0), 1'b1);

        // Reset mid-frame with a held word that must never appear
        send(0, 8'hFF, 1'b1);
        send(0, 8'h0F, 1'b0);
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        chk("rst_ready_comb", rdy[0], 1'b0);
        @(negedge clock);
        chk("rst_serial_out", so[0], 1'b0);
        chk("rst_bit_valid", bv[0], 1'b0);
        chk("rst_frame_done", fd[0], 1'b0);
        chk("rst_ready", rdy[0], 1'b0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_release_ready", rdy[0], 1'b1);
        repeat (20) @(negedge clock);

        // Recovery after reset
        send(0, 8'h5A, 1'b0);
        repeat (12) @(negedge clock);
        chk("final_msb_empty", 1'(q0.size() == 0), 1'b1);
        chk("final_lsb_empty", 1'(q1.size() == 0), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
